dt_infer_sched: RTL

Round-robin scheduler that shares one decision-tree evaluation datapath between `NUM_REQ` feature requesters. It accepts one feature vector at a time through a valid/ready handshake and looks up its branch in a runtime-writable 8-entry branch table. It then returns the prediction, tagged with the requester ID, through a backpressurable result port. It sits between the feature producers and the prediction consumer, and it is the only writer of the branch table.

---
 rtl/dt_pkg.sv | 34 +++
 rtl/rr_arbiter.sv | 38 +++
 rtl/dt_infer_sched.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/dt_pkg.sv
// Shared types, default branch table and branch-code decoding for the
// decision-tree inference scheduler.
package dt_pkg;

    typedef enum logic [1:0] {
        LEFT    = 2'b00,
        MIDDLE  = 2'b01,
        RIGHT   = 2'b10,
        INVALID = 2'b11
    } branch_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EVAL = 2'b01,
        RESP = 2'b10
    } state_e;

    localparam int DT_TABLE_DEPTH = 8;
    localparam int DT_IDX_W       = 3;

    localparam branch_e DT_DEFAULT_TABLE [DT_TABLE_DEPTH] = '{
        LEFT, MIDDLE, LEFT, RIGHT, RIGHT, LEFT, MIDDLE, RIGHT
    };

    // Returns {pred, err}; only the invalid code raises err.
    function automatic logic [1:0] branch_to_pred(input branch_e b);
        case (b)
            LEFT:          return 2'b00;
            MIDDLE, RIGHT: return 2'b10;
            default:       return 2'b01;
        endcase
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the search starts at ptr_i and wraps,
// granting the first active request. The pointer is owned by the caller.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    ptr_i,
    input  logic               en_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [ID_W-1:0]    gnt_idx_o
);

    int             idx;
    logic [ID_W-1:0] sel;
    logic            found;

    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        found     = 1'b0;
        idx       = 0;
        sel       = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            idx = int'(ptr_i) + off;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            sel = ID_W'(idx);
            if (en_i && !found && req_i[sel]) begin
                found      = 1'b1;
                gnt_o[sel] = 1'b1;
                gnt_idx_o  = sel;
            end
        end
    end

endmodule

// File: rtl/dt_infer_sched.sv
// Shares one decision-tree lookup between NUM_REQ requesters: round-robin
// accept in IDLE, table lookup in EVAL, hold the result in RESP until taken.
module dt_infer_sched
    import dt_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int FEAT_W  = 3,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*FEAT_W-1:0] req_features,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      cfg_we,
    input  logic [FEAT_W-1:0]         cfg_addr,
    input  logic [1:0]                cfg_data,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic                      res_pred,
    output logic                      res_err,
    output logic [ID_W-1:0]           res_id,
    output logic [15:0]               res_count,
    output logic                      busy
);

    localparam int DEPTH = 1 << FEAT_W;

    state_e          state_q, state_d;
    logic [ID_W-1:0] ptr_q, ptr_d;
    logic [ID_W-1:0] id_q, id_d;
    logic [ID_W-1:0] res_id_q, res_id_d;
    logic [FEAT_W-1:0] feat_q, feat_d;
    logic            pred_q, pred_d;
    logic            err_q, err_d;
    logic [15:0]     count_q, count_d;

    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]    gnt_idx;
    logic [FEAT_W-1:0]  gnt_feat;
    logic               gnt_en;
    logic [1:0]         lookup;

    branch_e tbl_q [DEPTH];

    // Grants are suppressed while reset is held so req_ready reads 0 then.
    assign gnt_en = (state_q == IDLE) && rst_n;

    rr_arbiter #(
        .NUM_REQ(NUM_REQ),
        .ID_W   (ID_W)
    ) u_arb (
        .req_i    (req_valid),
        .ptr_i    (ptr_q),
        .en_i     (gnt_en),
        .gnt_o    (gnt),
        .gnt_idx_o(gnt_idx)
    );

    always_comb begin
        gnt_feat = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                gnt_feat = req_features[i*FEAT_W +: FEAT_W];
            end
        end
    end

    // Nonblocking table writes make an EVAL read in the same cycle see the old entry.
    assign lookup = branch_to_pred(tbl_q[feat_q]);

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        feat_d   = feat_q;
        id_d     = id_q;
        res_id_d = res_id_q;
        pred_d   = pred_q;
        err_d    = err_q;
        count_d  = count_q;
        case (state_q)
            IDLE: begin
                if (|gnt) begin
                    feat_d  = gnt_feat;
                    id_d    = gnt_idx;
                    ptr_d   = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
                    state_d = EVAL;
                end
            end
            EVAL: begin
                {pred_d, err_d} = lookup;
                res_id_d        = id_q;
                state_d         = RESP;
            end
            RESP: begin
                if (res_ready) begin
                    count_d = count_q + 16'd1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q    <= '0;
            feat_q   <= '0;
            id_q     <= '0;
            res_id_q <= '0;
            pred_q   <= 1'b0;
            err_q    <= 1'b0;
            count_q  <= '0;
        end else begin
            ptr_q    <= ptr_d;
            feat_q   <= feat_d;
            id_q     <= id_d;
            res_id_q <= res_id_d;
            pred_q   <= pred_d;
            err_q    <= err_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                tbl_q[FEAT_W'(i)] <= DT_DEFAULT_TABLE[DT_IDX_W'(i)];
            end
        end else if (cfg_we) begin
            tbl_q[cfg_addr] <= branch_e'(cfg_data);
        end
    end

    assign req_ready = gnt;
    assign res_valid = (state_q == RESP);
    assign res_pred  = pred_q;
    assign res_err   = err_q;
    assign res_id    = res_id_q;
    assign res_count = count_q;
    assign busy      = (state_q != IDLE);

endmodule
